// File: rtl/serial_load_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_load_sequencer: frames an MSB-first bit stream into an N-bit word  |
// | and strobes it into a downstream load/clear register. Rev 1.0             |
// +--------------------------------------------------------------------------+
module serial_load_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic [N-1:0] word_out,
  output logic         load,
  output logic         busy,
  output logic         frame_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [N-1:0]    shift, shift_nx, word_nx, shifted;
  logic [CW-1:0]   count, count_nx;
  logic            err_nx;

  assign shifted = {shift[N-2:0], bit_in};

  // Outputs decode the registered state only, so inputs never reach them combinationally.
  assign busy = (state == SHIFT);
  assign load = (state == EMIT);

  always_comb begin
    state_nx = state;
    shift_nx = shift;
    count_nx = count;
    word_nx  = word_out;
    err_nx   = frame_err;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
          shift_nx = '0;
          count_nx = '0;
        end
      end
      SHIFT: begin
        // A restart wins over a coincident bit; the bit is dropped.
        if (start) begin
          shift_nx = '0;
          count_nx = '0;
          if (count != '0) err_nx = 1'b1;
        end else if (bit_valid) begin
          shift_nx = shifted;
          count_nx = count + CW'(1);
          if (count == LAST_IDX) begin
            word_nx  = shifted;
            state_nx = EMIT;
          end
        end
      end
      EMIT: begin
        if (start) begin
          state_nx = SHIFT;
          shift_nx = '0;
          count_nx = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      shift     <= '0;
      count     <= '0;
      word_out  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      count     <= count_nx;
      word_out  <= word_nx;
      frame_err <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_load_sequencer.md
Name: serial_load_sequencer

Overview:
- Upstream feeder for the N-bit load/clear register in the datapath.
- Collects a framed serial bit stream MSB-first into an N-bit word.
- Presents the word on `word_out` together with a single-cycle `load` strobe, which connect straight to the downstream register's `in` and `load`.
- Guarantees that `word_out` is stable whenever `load` is high and holds between frames, so the downstream register never sees a partial word.

Parameters:
N  8  word width; must be >= 2; must match downstream register N

Ports:
clk  input  1  rising-edge clock, sole clock domain
clear  input  1  synchronous active-high reset, sampled on rising edge of clk
start  input  1  frame start pulse; begins (or restarts) collection of a new word
bit_in  input  1  serial data bit, MSB first
bit_valid  input  1  bit_in is valid this cycle
word_out  output  N  assembled word, registered, to downstream register in
load  output  1  one-cycle strobe to downstream register load
busy  output  1  high while a frame is being collected (state SHIFT)
frame_err  output  1  sticky flag: a frame was aborted by start before completion

Behaviour:
- All state updates occur on the rising edge of clk. No combinational path from inputs to outputs.
- Reset:
  - `clear`=1 at a clock edge forces state=IDLE, shift register=0, bit count=0.
  - It also forces `word_out`=0, `load`=0, `busy`=0, `frame_err`=0.
  - `clear` overrides every other input, including mid-frame and in EMIT, where the pending strobe is cancelled.
- State IDLE:
  - `bit_valid` is ignored.
  - `start`=1 -> SHIFT, with count=0 and shift=0.
- State SHIFT:
  - `busy`=1.
  - Each cycle with `bit_valid`=1: shift <= {shift[N-2:0], bit_in}, count <= count+1.
  - On the edge that accepts the Nth bit: `word_out` <= {shift[N-2:0], bit_in}, state -> EMIT.
  - `start`=1 in SHIFT restarts the frame: count=0, shift=0, stay in SHIFT, and `frame_err` <= 1 if count != 0.
  - `start` takes priority over `bit_valid` in the same cycle; that bit is discarded.
- State EMIT (exactly one cycle):
  - `load`=1 and `busy`=0.
  - Next state is IDLE, or SHIFT if `start`=1 in this cycle.
  - `bit_valid` is ignored.
- Latency: `load` is high in the cycle immediately after the edge that accepted bit N-1 (the Nth bit). The downstream register captures `word_out` at the end of that cycle.
- Strobe rules:
  - `load` is never high for two consecutive cycles.
  - `word_out` changes only on the edge entering EMIT, or on `clear`.
  - `word_out` holds its value through IDLE and through subsequent SHIFT phases.
- Gaps: `bit_valid` may be low for any number of cycles inside a frame. The count does not advance and there is no timeout.
- Count width: clog2(N+1) bits. Count never exceeds N; it is reset on entering SHIFT.
- `frame_err` is cleared only by `clear`.

Test Plan:
1. Reset, then `start`, then 8 consecutive `bit_valid` with bits 1,0,1,1,0,0,1,0 -> `load`=1 for exactly one cycle, one cycle after the 8th bit; `word_out`=8'hB2; `busy`=1 during the 8 bit cycles only.
2. Same frame as scenario 1 with `bit_valid` low for 3 cycles after bits 2 and 5 -> `word_out`=8'hB2; `load` one cycle after the last bit; no strobe earlier.
3. `start`, 4 bits (1111), then `start` again, then 8 bits 8'h0F -> `frame_err`=1 and stays 1; single `load` with `word_out`=8'h0F; no strobe for the aborted frame.
4. Frame 8'hA5 completes; `start` is asserted in the EMIT cycle, followed by 8 bits 8'h3C -> `load` pulses for A5, then for 3C; `word_out` holds A5 until the 3C EMIT edge.
5. `clear` asserted after 6 bits of a frame, and separately in the EMIT cycle -> next cycle all outputs 0, state IDLE, no `load`; subsequent `bit_valid` without `start` produces no `load`.
6. `start` and `bit_valid`=1 in the same cycle, followed by 8 bits 8'hFF -> the coincident bit is discarded; exactly one `load` with `word_out`=8'hFF after the 8 later bits.
